// File: rtl/filtro_pkg.sv
// Shared types and constant helpers for the filtro_mac FIR engine.
package filtro_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MAC   = 2'd1,
        ROUND = 2'd2
    } state_t;

    // Guard bits of clog2(TAPS) keep the running sum of full-width products from overflowing.
    function automatic int acc_w(input int width, input int taps);
        return 2 * width + $clog2(taps);
    endfunction

    function automatic longint round_const(input int frac, input int mode);
        if (mode == 1 && frac > 0)
            return longint'(1) << (frac - 1);
        return longint'(0);
    endfunction

    function automatic longint sat_max(input int width);
        return (longint'(1) << (width - 1)) - longint'(1);
    endfunction

    function automatic longint sat_min(input int width);
        return -(longint'(1) << (width - 1));
    endfunction

endpackage

// File: rtl/filtro_sat_trunc.sv
// Output stage: optional half-up rounding, arithmetic shift by FRAC, clip to WIDTH bits.
module filtro_sat_trunc
    import filtro_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int TAPS       = 8,
    parameter int ROUND_MODE = 0,
    localparam int ACC_W     = acc_w(WIDTH, TAPS)
) (
    input  logic signed [ACC_W-1:0] acc,
    output logic signed [WIDTH-1:0] dout_next,
    output logic                    sat_next
);

    localparam logic signed [ACC_W-1:0] RND = ACC_W'(round_const(FRAC, ROUND_MODE));
    localparam logic signed [ACC_W-1:0] HI  = ACC_W'(sat_max(WIDTH));
    localparam logic signed [ACC_W-1:0] LO  = ACC_W'(sat_min(WIDTH));

    function automatic logic signed [ACC_W-1:0] round_shift(input logic signed [ACC_W-1:0] a);
        return (a + RND) >>> FRAC;
    endfunction

    function automatic logic [WIDTH:0] saturate(input logic signed [ACC_W-1:0] a);
        if (a > HI)
            return {1'b1, HI[WIDTH-1:0]};
        if (a < LO)
            return {1'b1, LO[WIDTH-1:0]};
        return {1'b0, a[WIDTH-1:0]};
    endfunction

    logic signed [ACC_W-1:0] shifted;
    logic        [WIDTH:0]   clipped;

    always_comb begin
        shifted   = round_shift(acc);
        clipped   = saturate(shifted);
        sat_next  = clipped[WIDTH];
        dout_next = clipped[WIDTH-1:0];
    end

endmodule

// File: rtl/filtro_mac.sv
// Time-multiplexed FIR: one signed MAC per clock over a circular delay line,
// then a registered rounding/saturation stage.
module filtro_mac
    import filtro_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int FRAC       = 8,
    parameter int TAPS       = 8,
    parameter int ROUND_MODE = 0
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [WIDTH-1:0]         din,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic                     coef_we,
    input  logic [$clog2(TAPS)-1:0]  coef_addr,
    input  logic [WIDTH-1:0]         coef_data,
    output logic [WIDTH-1:0]         dout,
    output logic                     dout_valid,
    output logic                     sat
);

    localparam int PW    = $clog2(TAPS);
    localparam int ACC_W = acc_w(WIDTH, TAPS);

    state_t state, state_n;

    logic accept, mac_en, round_en, last_tap;

    logic [PW-1:0] wr_ptr, tap, rd_idx;
    logic signed [WIDTH-1:0]   xline [TAPS];
    logic signed [WIDTH-1:0]   coef  [TAPS];
    logic signed [2*WIDTH-1:0] prod_p1;
    logic signed [ACC_W-1:0]   acc_p1;
    logic signed [WIDTH-1:0]   dout_next;
    logic                      sat_next;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (din_valid) state_n = MAC;
            MAC:     if (last_tap)  state_n = ROUND;
            ROUND:   state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_comb begin
        din_ready = (state == IDLE);
        accept    = (state == IDLE) && din_valid;
        mac_en    = (state == MAC);
        round_en  = (state == ROUND);
    end

    // Newest sample sits at wr_ptr; tap k reads k slots behind it, modulo TAPS.
    always_comb begin
        last_tap = (tap == PW'(TAPS - 1));
        if (wr_ptr >= tap)
            rd_idx = wr_ptr - tap;
        else
            rd_idx = wr_ptr + PW'(TAPS) - tap;
        prod_p1 = coef[tap] * xline[rd_idx];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            tap        <= '0;
            acc_p1     <= '0;
            dout       <= '0;
            sat        <= 1'b0;
            dout_valid <= 1'b0;
            for (int i = 0; i < TAPS; i++) begin
                xline[i] <= '0;
                coef[i]  <= '0;
            end
        end else begin
            dout_valid <= round_en;
            if (din_ready && coef_we)
                coef[coef_addr] <= coef_data;
            if (accept) begin
                xline[wr_ptr] <= din;
                acc_p1        <= '0;
                tap           <= '0;
            end
            if (mac_en) begin
                acc_p1 <= acc_p1 + $signed({{(ACC_W-2*WIDTH){prod_p1[2*WIDTH-1]}}, prod_p1});
                tap    <= tap + 1'b1;
            end
            // ---- round / saturate stage ----
            if (round_en) begin
                dout   <= dout_next;
                sat    <= sat_next;
                wr_ptr <= (wr_ptr == PW'(TAPS - 1)) ? '0 : wr_ptr + 1'b1;
            end
        end
    end

    filtro_sat_trunc #(
        .WIDTH      (WIDTH),
        .FRAC       (FRAC),
        .TAPS       (TAPS),
        .ROUND_MODE (ROUND_MODE)
    ) u_sat_trunc (
        .acc       (acc_p1),
        .dout_next (dout_next),
        .sat_next  (sat_next)
    );

endmodule

// File: tb/tb_filtro_mac.sv
// Directed bench for filtro_mac (WIDTH=16, FRAC=8, TAPS=4); a second instance runs with ROUND_MODE=1.
module tb_filtro_mac;

    logic        clk;
    logic        rst;
    logic [15:0] din;
    logic        din_valid;
    logic        din_ready, din_ready_r;
    logic        coef_we;
    logic [1:0]  coef_addr;
    logic [15:0] coef_data;
    logic [15:0] dout, dout_r;
    logic        dout_valid, dout_valid_r;
    logic        sat, sat_r;

    int errors = 0;
    int checks = 0;

    filtro_mac #(.WIDTH(16), .FRAC(8), .TAPS(4), .ROUND_MODE(0)) dut (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .dout(dout), .dout_valid(dout_valid), .sat(sat)
    );

    filtro_mac #(.WIDTH(16), .FRAC(8), .TAPS(4), .ROUND_MODE(1)) dut_r (
        .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready_r),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .dout(dout_r), .dout_valid(dout_valid_r), .sat(sat_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_coef(input logic [1:0] a, input logic [15:0] d);
        coef_we = 1'b1; coef_addr = a; coef_data = d;
        tick();
        coef_we = 1'b0;
    endtask

    task automatic load_coefs(input logic [15:0] c0, input logic [15:0] c1,
                              input logic [15:0] c2, input logic [15:0] c3);
        write_coef(2'd0, c0);
        write_coef(2'd1, c1);
        write_coef(2'd2, c2);
        write_coef(2'd3, c3);
    endtask

    // Offers one sample, waits for its result; optionally strobes a coefficient write during MAC.
    task automatic send(input logic [15:0] sample, input bit we_in_mac,
                        output logic [15:0] d, output logic [15:0] dr,
                        output logic s, output int lat);
        int n;
        din = sample; din_valid = 1'b1;
        n = 0;
        while (!din_ready && n < 50) begin tick(); n++; end
        if (!din_ready) chk("accept_timeout", 32'd0, 32'd1);
        tick();
        din_valid = 1'b0;
        if (we_in_mac) begin
            coef_we = 1'b1; coef_addr = 2'd0; coef_data = 16'h1234;
        end
        lat = 0;
        while (!dout_valid && lat < 20) begin
            tick();
            lat++;
            coef_we = 1'b0;
        end
        if (!dout_valid) chk("dout_timeout", 32'd0, 32'd1);
        d = dout; dr = dout_r; s = sat;
    endtask

    logic [15:0] d, dr;
    logic        s;
    int          lat;
    int          acc_cyc[$];
    int          vcount;
    logic [15:0] imp_exp [4] = '{16'h0100, 16'h0080, 16'h0040, 16'hFF80};
    logic [15:0] wrap_exp[5] = '{16'h0100, 16'h0080, 16'h0040, 16'hFF80, 16'h0000};

    initial begin
        rst = 1'b1; din = '0; din_valid = 1'b0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        tick(); tick();
        rst = 1'b0;
        tick();
        chk("rst_ready", din_ready, 1);
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_sat", sat, 0);

        // Impulse response
        load_coefs(16'h0100, 16'h0080, 16'h0040, 16'hFF80);
        for (int i = 0; i < 4; i++) begin
            send((i == 0) ? 16'h0100 : 16'h0000, 1'b0, d, dr, s, lat);
            chk($sformatf("imp_dout%0d", i), d, imp_exp[i]);
            chk($sformatf("imp_sat%0d", i), s, 0);
            chk($sformatf("imp_lat%0d", i), lat, 5);
        end

        // Continuous DIN_VALID: one accept every TAPS+2 cycles
        din = 16'h0000; din_valid = 1'b1;
        for (int c = 0; c < 24; c++) begin
            if (din_ready) acc_cyc.push_back(c);
            tick();
        end
        din_valid = 1'b0;
        repeat (8) tick();
        chk("hs_count", acc_cyc.size(), 4);
        for (int i = 1; i < acc_cyc.size(); i++)
            chk($sformatf("hs_gap%0d", i), acc_cyc[i] - acc_cyc[i-1], 6);
        chk("hs_flush_dout", dout, 16'h0000);

        // Coefficient write during MAC must be ignored
        send(16'h0100, 1'b1, d, dr, s, lat);
        chk("we_mac_dout0", d, 16'h0100);
        send(16'h0000, 1'b0, d, dr, s, lat);
        chk("we_mac_dout1", d, 16'h0080);

        // Rounding: product 0x80 and -0x80 with c0=1
        load_coefs(16'h0001, 16'h0000, 16'h0000, 16'h0000);
        send(16'h0080, 1'b0, d, dr, s, lat);
        chk("rnd_trunc_pos", d, 16'h0000);
        chk("rnd_half_pos", dr, 16'h0001);
        chk("rnd_vld", dout_valid_r, 1);
        send(16'hFF80, 1'b0, d, dr, s, lat);
        chk("rnd_trunc_neg", d, 16'hFFFF);
        chk("rnd_half_neg", dr, 16'h0000);
        chk("rnd_sat_r", sat_r, 0);

        // Saturation
        load_coefs(16'h7FFF, 16'h7FFF, 16'h7FFF, 16'h7FFF);
        for (int i = 0; i < 4; i++) send(16'h7FFF, 1'b0, d, dr, s, lat);
        chk("sat_pos_dout", d, 16'h7FFF);
        chk("sat_pos_flag", s, 1);
        for (int i = 0; i < 4; i++) send(16'h8000, 1'b0, d, dr, s, lat);
        chk("sat_neg_dout", d, 16'h8000);
        chk("sat_neg_flag", s, 1);
        repeat (3) tick();
        chk("sat_hold_dout", dout, 16'h8000);
        chk("sat_hold_flag", sat, 1);

        // Reset on the 2nd MAC cycle
        din = 16'h0100; din_valid = 1'b1;
        tick();
        din_valid = 1'b0;
        tick();
        rst = 1'b1;
        #1;
        chk("mrst_ready", din_ready, 1);
        chk("mrst_dout", dout, 0);
        chk("mrst_sat", sat, 0);
        vcount = 0;
        for (int c = 0; c < 10; c++) begin
            tick();
            rst = 1'b0;
            if (dout_valid) vcount++;
        end
        chk("mrst_no_valid", vcount, 0);
        send(16'h0100, 1'b0, d, dr, s, lat);
        chk("mrst_imp_dout", d, 16'h0000);
        chk("mrst_imp_lat", lat, 5);

        // Wrap-around: nine samples, impulse on the fifth
        load_coefs(16'h0100, 16'h0080, 16'h0040, 16'hFF80);
        for (int i = 1; i <= 9; i++) begin
            send((i == 5) ? 16'h0100 : 16'h0000, 1'b0, d, dr, s, lat);
            if (i >= 5) chk($sformatf("wrap_out%0d", i), d, wrap_exp[i-5]);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/filtro_mac.md
# filtro_mac

Parametrised, time-multiplexed fixed-point FIR engine: one signed multiply-accumulate per clock over a circular delay line of TAPS samples, followed by a rounding and saturation stage. It replaces the fixed-width, single-pass sign-extend / multiply / add / truncate chain in the arithmetic path. It adds runtime-loadable coefficients, a valid/ready sample handshake, a selectable rounding mode and a saturation flag. It sits between the sample acquisition logic and the output formatter, clocked by the global clock.

## Interface
- WIDTH, 16: sample, coefficient and output width; two's complement.
- FRAC, 8: fractional bits of samples and coefficients (Q(WIDTH-FRAC).FRAC).
- TAPS, 8: filter length; must be ≥2.
- ROUND_MODE, 0: 0 = truncate toward −∞; 1 = round half up.
- CLK, in, 1: single clock, rising edge.
- RST, in, 1: reset, asynchronous, active-high.
- DIN, in, WIDTH: input sample.
- DIN_VALID, in, 1: DIN is valid.
- DIN_READY, out, 1: engine accepts a sample this cycle.
- COEF_WE, in, 1: coefficient write strobe.
- COEF_ADDR, in, clog2(TAPS): coefficient index.
- COEF_DATA, in, WIDTH: coefficient value.
- DOUT, out, WIDTH: filtered output sample.
- DOUT_VALID, out, 1: one-cycle pulse; DOUT is new.
- SAT, out, 1: the current DOUT was clipped; held with DOUT.

## Operation
- Output is y[n] = Σ c[k]·x[n−k] for k = 0..TAPS−1. Delay-line slots that have never been written contribute zero.
- Accumulator width is ACC_W = 2·WIDTH + clog2(TAPS). Products are full 2·WIDTH signed and are sign-extended into the accumulator, which never overflows.
- Output stage:
  - ROUND_MODE=1 adds 2^(FRAC−1) to the accumulator first.
  - The result is arithmetic-shifted right by FRAC.
  - It is then saturated to [−2^(WIDTH−1), 2^(WIDTH−1)−1].
  - SAT=1 iff clipping occurred.
- FSM states:
  - IDLE: DIN_READY=1. On DIN_VALID, write DIN at the write pointer, clear the accumulator and tap index, go to MAC.
  - MAC: each cycle, acc += c[k]·x[ptr−k mod TAPS] and k increments. After k = TAPS−1, go to ROUND.
  - ROUND: register DOUT and SAT, pulse DOUT_VALID, advance the write pointer (mod TAPS), go to IDLE.
- Coefficient writes take effect only while in IDLE. In any other state COEF_WE is ignored and the coefficient is left unchanged.
- COEF_WE together with DIN_VALID in IDLE: both are performed. The new coefficient is used in the MAC that starts on the next cycle.
- DIN_VALID outside IDLE: there is no handshake and the sample is not consumed. The source must hold it.
- Write-pointer wrap: TAPS−1 → 0. The oldest sample is overwritten.

## Timing
- Reset values: DIN_READY=1 (state IDLE), DOUT=0, DOUT_VALID=0, SAT=0, write pointer=0, delay line all 0, coefficients all 0.
- Handshake on accept edge E0. MACs occur on edges E1..E_TAPS. DOUT, SAT and DOUT_VALID are registered on edge E_TAPS+1, so latency is TAPS+1 edges.
- DIN_READY is high again in the DOUT_VALID cycle. Maximum throughput is one sample per TAPS+2 cycles.
- DOUT and SAT hold until the next ROUND.
- RST asserted at any point, including mid-MAC: all state returns to reset values immediately, the in-flight sample is discarded, and no DOUT_VALID is produced.
- All outputs are registered; there is no combinational path from input to output.

## Structure
- Package filtro_pkg holds:
  - the state enumeration (IDLE, MAC, ROUND);
  - the ACC_W computation function;
  - the rounding constant and saturation-bound helpers.
- Sub-module filtro_sat_trunc is combinational: accumulator in; rounding, shift and saturation applied; DOUT_next and SAT_next out. It is the generalised truncation stage.
- Delay line and coefficient bank are register arrays; no RAM inference is required at TAPS=8.

## Test plan
All scenarios use WIDTH=16, FRAC=8, TAPS=4.
- Impulse response:
  - Stimulus: coefs 0x0100, 0x0080, 0x0040, 0xFF80; DIN=0x0100 followed by three 0x0000.
  - Required: DOUT sequence 0x0100, 0x0080, 0x0040, 0xFF80; SAT=0 throughout.
  - Required: each DOUT_VALID exactly 5 edges after its accept.
- Positive saturation:
  - Stimulus: all coefs 0x7FFF; four samples 0x7FFF.
  - Required: 4th DOUT=0x7FFF with SAT=1.
  - Stimulus: all samples 0x8000.
  - Required: DOUT=0x8000 with SAT=1.
- Rounding:
  - Stimulus: c[0]=0x0001, DIN=0x0080 (product 0x80).
  - Required: ROUND_MODE=0 gives DOUT=0x0000; ROUND_MODE=1 gives DOUT=0x0001.
- Handshake and coefficient-write rules:
  - Stimulus: DIN_VALID held high continuously.
  - Required: accepts exactly every 6 cycles.
  - Stimulus: COEF_WE pulsed during MAC.
  - Required: the coefficient is unchanged on readback via the impulse test.
- Reset mid-operation:
  - Stimulus: assert RST on the 2nd MAC cycle.
  - Required: DOUT=0, DOUT_VALID never pulses, DIN_READY=1 immediately.
  - Required: a following impulse yields the zero-history response (coefficients also zeroed → DOUT=0x0000).
- Wrap-around:
  - Stimulus: 9 samples with the impulse on the 5th.
  - Required: outputs 5–8 equal the coefficient sequence and output 9 equals 0x0000. This confirms that the pointer wrap and overwrite are correct.
